// File: rtl/alu_control_sequencer_pkg.sv
// Shared definitions for the multi-cycle ALU control sequencer: opcodes, FSM states, flag layout.
package alu_control_sequencer_pkg;

    localparam logic [5:0] OP_RALU = 6'h00;
    localparam logic [5:0] OP_IALU = 6'h01;
    localparam logic [5:0] OP_LW   = 6'h02;
    localparam logic [5:0] OP_SW   = 6'h03;
    localparam logic [5:0] OP_BZ   = 6'h04;
    localparam logic [5:0] OP_BNZ  = 6'h05;
    localparam logic [5:0] OP_BLTZ = 6'h06;
    localparam logic [5:0] OP_BCY  = 6'h07;
    localparam logic [5:0] OP_B    = 6'h08;
    localparam logic [5:0] OP_HALT = 6'h09;

    localparam logic [5:0] NEG_FUNCT_DEFAULT = 6'h02;

    // Bit positions inside the latched {carry, zero, sign} flag vector.
    localparam int unsigned FLAG_CY = 2;
    localparam int unsigned FLAG_Z  = 1;
    localparam int unsigned FLAG_S  = 0;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    function automatic logic is_legal_op(input logic [5:0] op);
        return op <= OP_HALT;
    endfunction

    function automatic logic is_alu_op(input logic [5:0] op);
        return (op == OP_RALU) || (op == OP_IALU);
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/alu_control_sequencer_branch_cond_eval.sv
// Combinational branch decision: opcode and latched flags in, taken out.
module branch_cond_eval
    import alu_control_sequencer_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [2:0] i_flags,
    output logic       o_is_branch,
    output logic       o_taken
);

    always_comb begin
        o_is_branch = 1'b1;
        o_taken     = 1'b0;
        case (i_opcode)
            OP_BZ:   o_taken = i_flags[FLAG_Z];
            OP_BNZ:  o_taken = ~i_flags[FLAG_Z];
            OP_BLTZ: o_taken = i_flags[FLAG_S];
            OP_BCY:  o_taken = i_flags[FLAG_CY];
            OP_B:    o_taken = 1'b1;
            default: o_is_branch = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_control_sequencer.sv
// Multi-cycle control FSM: fetch, decode to ALU control, branch on latched flags, memory handshake.
module alu_control_sequencer
    import alu_control_sequencer_pkg::*;
#(
    parameter logic [5:0] NEG_FUNCT       = NEG_FUNCT_DEFAULT,
    parameter bit         HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_instr,
    input  logic        i_mem_ready,
    input  logic        i_carry,
    input  logic        i_zero,
    input  logic        i_sign,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_ir_load,
    output logic [5:0]  o_alu_op,
    output logic        o_alu_sel,
    output logic        o_alu_src_imm,
    output logic        o_reg_we,
    output logic        o_wb_from_mem,
    output logic        o_pc_inc,
    output logic        o_pc_branch,
    output logic [2:0]  o_flags_q,
    output logic        o_halted,
    output logic        o_illegal
);

    state_e     r_state;
    logic [5:0] r_opcode;
    logic [5:0] r_funct;
    logic [2:0] r_flags;
    logic       r_illegal;
    logic       r_halted;
    logic [5:0] r_alu_op;
    logic       r_alu_sel;
    logic       r_alu_src_imm;
    logic       r_reg_we;
    logic       r_wb_from_mem;

    state_e     w_state_d;
    logic       w_set_illegal;
    logic       w_is_alu;
    logic       w_is_branch;
    logic       w_taken;
    logic       w_fetch_done;
    logic       w_next_exec_alu;
    logic       w_unused_instr;

    assign w_unused_instr = ^i_instr[25:6];
    assign w_is_alu       = is_alu_op(r_opcode);

    branch_cond_eval u_branch_cond_eval (
        .i_opcode    (r_opcode),
        .i_flags     (r_flags),
        .o_is_branch (w_is_branch),
        .o_taken     (w_taken)
    );

    always_comb begin
        w_state_d     = r_state;
        w_set_illegal = 1'b0;
        case (r_state)
            StFetch: begin
                if (i_mem_ready) w_state_d = StDecode;
            end
            StDecode: begin
                if (r_opcode == OP_HALT) begin
                    w_state_d = StHalt;
                end else if (!is_legal_op(r_opcode)) begin
                    w_set_illegal = 1'b1;
                    w_state_d     = HALT_ON_ILLEGAL ? StHalt : StFetch;
                end else begin
                    w_state_d = StExec;
                end
            end
            StExec: begin
                if (w_is_alu)                    w_state_d = StWb;
                else if (is_mem_op(r_opcode))    w_state_d = StMem;
                else if (w_is_branch)            w_state_d = StFetch;
                else                             w_state_d = StFetch;
            end
            StMem: begin
                if (i_mem_ready) w_state_d = (r_opcode == OP_LW) ? StWb : StFetch;
            end
            StWb:    w_state_d = StFetch;
            StHalt:  w_state_d = StHalt;
            default: w_state_d = StFetch;
        endcase
    end

    assign w_next_exec_alu = (w_state_d == StExec) && w_is_alu;

    // EXEC/WB/HALT outputs are registered from the next state, so they line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StFetch;
            r_opcode      <= '0;
            r_funct       <= '0;
            r_flags       <= '0;
            r_illegal     <= 1'b0;
            r_halted      <= 1'b0;
            r_alu_op      <= '0;
            r_alu_sel     <= 1'b0;
            r_alu_src_imm <= 1'b0;
            r_reg_we      <= 1'b0;
            r_wb_from_mem <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_fetch_done) begin
                r_opcode <= i_instr[31:26];
                r_funct  <= i_instr[5:0];
            end
            if ((r_state == StExec) && w_is_alu) begin
                r_flags <= {i_carry, i_zero, i_sign};
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            r_alu_op      <= w_next_exec_alu ? r_funct : 6'h00;
            r_alu_sel     <= w_next_exec_alu && (r_funct == NEG_FUNCT);
            r_alu_src_imm <= (w_state_d == StExec)
                             && ((r_opcode == OP_IALU) || is_mem_op(r_opcode));
            r_reg_we      <= (w_state_d == StWb);
            r_wb_from_mem <= (w_state_d == StWb) && (r_opcode == OP_LW);
            r_halted      <= (w_state_d == StHalt);
        end
    end

    // Handshake strobes stay combinational so a reset drops them within the same cycle.
    assign w_fetch_done  = !rst && (r_state == StFetch) && i_mem_ready;
    assign o_mem_req     = !rst && ((r_state == StFetch) || (r_state == StMem));
    assign o_mem_we      = !rst && (r_state == StMem) && (r_opcode == OP_SW);
    assign o_ir_load     = w_fetch_done;
    assign o_pc_inc      = w_fetch_done;
    assign o_pc_branch   = !rst && (r_state == StExec) && w_taken;

    assign o_alu_op      = r_alu_op;
    assign o_alu_sel     = r_alu_sel;
    assign o_alu_src_imm = r_alu_src_imm;
    assign o_reg_we      = r_reg_we;
    assign o_wb_from_mem = r_wb_from_mem;
    assign o_flags_q     = r_flags;
    assign o_halted      = r_halted;
    assign o_illegal     = r_illegal;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed bench for alu_control_sequencer: per-cycle expected output vectors per scenario.
module tb_alu_control_sequencer;

    localparam logic [15:0] E_SEL   = 16'h0200;
    localparam logic [15:0] E_REQ   = 16'h0100;
    localparam logic [15:0] E_WE    = 16'h0080;
    localparam logic [15:0] E_IRL   = 16'h0040;
    localparam logic [15:0] E_PCI   = 16'h0020;
    localparam logic [15:0] E_BR    = 16'h0010;
    localparam logic [15:0] E_IMM   = 16'h0008;
    localparam logic [15:0] E_RWE   = 16'h0004;
    localparam logic [15:0] E_WBM   = 16'h0002;
    localparam logic [15:0] E_HLT   = 16'h0001;
    localparam logic [15:0] E_FETCH = E_REQ | E_IRL | E_PCI;

    localparam logic [31:0] I_RALU5  = {6'h00, 20'h0, 6'h05};
    localparam logic [31:0] I_RALU0  = {6'h00, 26'h0};
    localparam logic [31:0] I_RALU21 = {6'h00, 20'h0, 6'h21};
    localparam logic [31:0] I_NEG    = {6'h01, 20'h0, 6'h02};
    localparam logic [31:0] I_LW     = {6'h02, 26'h0};
    localparam logic [31:0] I_SW     = {6'h03, 26'h0};
    localparam logic [31:0] I_BZ     = {6'h04, 26'h0};
    localparam logic [31:0] I_BNZ    = {6'h05, 26'h0};
    localparam logic [31:0] I_BLTZ   = {6'h06, 26'h0};
    localparam logic [31:0] I_BCY    = {6'h07, 26'h0};
    localparam logic [31:0] I_B      = {6'h08, 26'h0};
    localparam logic [31:0] I_HALT   = {6'h09, 26'h0};
    localparam logic [31:0] I_ILL    = {6'h3F, 26'h0};
    localparam logic [31:0] I_JUNK   = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready, carry, zero, sign;

    logic        mem_req, mem_we, ir_load, alu_sel, alu_src_imm, reg_we, wb_from_mem;
    logic        pc_inc, pc_branch, halted, illegal;
    logic [5:0]  alu_op;
    logic [2:0]  flags_q;
    logic        mem_req_h, mem_we_h, ir_load_h, alu_sel_h, alu_src_imm_h, reg_we_h;
    logic        wb_from_mem_h, pc_inc_h, pc_branch_h, halted_h, illegal_h;
    logic [5:0]  alu_op_h;
    logic [2:0]  flags_q_h;
    logic [15:0] obs, obs_h;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_control_sequencer #(.HALT_ON_ILLEGAL(1'b0)) u_dut (
        .clk(clk), .rst(rst), .i_instr(instr), .i_mem_ready(mem_ready),
        .i_carry(carry), .i_zero(zero), .i_sign(sign),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_ir_load(ir_load), .o_alu_op(alu_op),
        .o_alu_sel(alu_sel), .o_alu_src_imm(alu_src_imm), .o_reg_we(reg_we),
        .o_wb_from_mem(wb_from_mem), .o_pc_inc(pc_inc), .o_pc_branch(pc_branch),
        .o_flags_q(flags_q), .o_halted(halted), .o_illegal(illegal)
    );

    alu_control_sequencer #(.HALT_ON_ILLEGAL(1'b1)) u_dut_h (
        .clk(clk), .rst(rst), .i_instr(instr), .i_mem_ready(mem_ready),
        .i_carry(carry), .i_zero(zero), .i_sign(sign),
        .o_mem_req(mem_req_h), .o_mem_we(mem_we_h), .o_ir_load(ir_load_h),
        .o_alu_op(alu_op_h), .o_alu_sel(alu_sel_h), .o_alu_src_imm(alu_src_imm_h),
        .o_reg_we(reg_we_h), .o_wb_from_mem(wb_from_mem_h), .o_pc_inc(pc_inc_h),
        .o_pc_branch(pc_branch_h), .o_flags_q(flags_q_h), .o_halted(halted_h),
        .o_illegal(illegal_h)
    );

    assign obs   = {alu_op, alu_sel, mem_req, mem_we, ir_load, pc_inc, pc_branch,
                    alu_src_imm, reg_we, wb_from_mem, halted};
    assign obs_h = {alu_op_h, alu_sel_h, mem_req_h, mem_we_h, ir_load_h, pc_inc_h,
                    pc_branch_h, alu_src_imm_h, reg_we_h, wb_from_mem_h, halted_h};

    task automatic do_reset();
        rst = 1'b1;
        instr = I_JUNK;
        mem_ready = 1'b0;
        {carry, zero, sign} = 3'b000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_ralu();
        logic [31:0] ins [5];
        logic [4:0]  mr;
        logic [2:0]  fl [5];
        logic [15:0] ex [5];
        ins = '{I_RALU5, I_JUNK, I_JUNK, I_JUNK, I_JUNK};
        mr  = 5'b11110;
        fl  = '{3'b000, 3'b000, 3'b101, 3'b000, 3'b000};
        ex  = '{E_FETCH, 16'h0000, {6'h05, 10'h000}, E_RWE, E_REQ};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            instr = ins[c]; mem_ready = mr[4-c]; {carry, zero, sign} = fl[c];
            #3;
            if (obs !== ex[c]) $display("FAIL ralu cyc%0d: got %h want %h", c + 1, obs, ex[c]);
            else n_pass++;
            n_checks++;
            @(posedge clk); #1;
        end
        #3;
        if (flags_q !== 3'b101) $display("FAIL ralu_flags: got %b want 101", flags_q);
        else n_pass++;
        n_checks++;
    endtask

    // Runs straight after test_ralu, so flags_q holds 101 and the FSM waits in FETCH.
    task automatic test_reset();
        mem_ready = 1'b0;
        #1;
        if (obs !== E_REQ) $display("FAIL reset_pre: got %h want %h", obs, E_REQ);
        else n_pass++;
        n_checks++;
        rst = 1'b1; mem_ready = 1'b1;
        #1;
        if (obs !== 16'h0000) $display("FAIL reset_async: got %h want 0000", obs);
        else n_pass++;
        n_checks++;
        if ({flags_q, illegal} !== 4'b0000)
            $display("FAIL reset_regs: got %b want 0000", {flags_q, illegal});
        else n_pass++;
        n_checks++;
        @(posedge clk); #1;
        if (obs !== 16'h0000) $display("FAIL reset_hold: got %h want 0000", obs);
        else n_pass++;
        n_checks++;
        rst = 1'b0; mem_ready = 1'b0;
        #3;
        if (obs !== E_REQ) $display("FAIL reset_fetch: got %h want %h", obs, E_REQ);
        else n_pass++;
        n_checks++;
        if (flags_q !== 3'b000) $display("FAIL reset_flags: got %b want 000", flags_q);
        else n_pass++;
        n_checks++;
        @(posedge clk); #1;
    endtask

    task automatic test_neg_illegal();
        logic [31:0] ins [7];
        logic [6:0]  mr;
        logic [2:0]  fl [7];
        logic [15:0] ex [7];
        ins = '{I_NEG, I_JUNK, I_JUNK, I_JUNK, I_ILL, I_JUNK, I_JUNK};
        mr  = 7'b1111110;
        fl  = '{3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
        ex  = '{E_FETCH, 16'h0000, {6'h02, 10'h000} | E_SEL | E_IMM, E_RWE, E_FETCH,
                16'h0000, E_REQ};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            instr = ins[c]; mem_ready = mr[6-c]; {carry, zero, sign} = fl[c];
            #3;
            if (obs !== ex[c]) $display("FAIL neg_ill cyc%0d: got %h want %h", c + 1, obs, ex[c]);
            else n_pass++;
            n_checks++;
            if (c == 5) begin
                if (illegal !== 1'b0) $display("FAIL ill_early: got %b want 0", illegal);
                else n_pass++;
                n_checks++;
            end
            @(posedge clk); #1;
        end
        #3;
        if ({illegal, illegal_h} !== 2'b11)
            $display("FAIL ill_sticky: got %b want 11", {illegal, illegal_h});
        else n_pass++;
        n_checks++;
        if (obs_h !== E_HLT) $display("FAIL ill_halt: got %h want %h", obs_h, E_HLT);
        else n_pass++;
        n_checks++;
        if (flags_q !== 3'b010) $display("FAIL neg_flags: got %b want 010", flags_q);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_branch();
        logic [31:0] ins [27];
        logic [26:0] mr;
        logic [2:0]  fl [27];
        logic [15:0] ex [27];
        ins = '{I_RALU0, I_JUNK, I_JUNK, I_JUNK,
                I_BZ, I_JUNK, I_JUNK, I_BNZ, I_JUNK, I_JUNK,
                I_BCY, I_JUNK, I_JUNK, I_B, I_JUNK, I_JUNK,
                I_RALU21, I_JUNK, I_JUNK, I_JUNK,
                I_BLTZ, I_JUNK, I_JUNK, I_BZ, I_JUNK, I_JUNK, I_JUNK};
        mr  = 27'b111111111111111111111111110;
        fl  = '{3'b000, 3'b000, 3'b010, 3'b000,
                3'b000, 3'b000, 3'b101, 3'b000, 3'b000, 3'b101,
                3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000,
                3'b000, 3'b000, 3'b101, 3'b000,
                3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000};
        ex  = '{E_FETCH, 16'h0000, 16'h0000, E_RWE,
                E_FETCH, 16'h0000, E_BR, E_FETCH, 16'h0000, 16'h0000,
                E_FETCH, 16'h0000, 16'h0000, E_FETCH, 16'h0000, E_BR,
                E_FETCH, 16'h0000, {6'h21, 10'h000}, E_RWE,
                E_FETCH, 16'h0000, E_BR, E_FETCH, 16'h0000, 16'h0000, E_REQ};
        do_reset();
        for (int c = 0; c < 27; c++) begin
            instr = ins[c]; mem_ready = mr[26-c]; {carry, zero, sign} = fl[c];
            #3;
            if (obs !== ex[c]) $display("FAIL branch cyc%0d: got %h want %h", c + 1, obs, ex[c]);
            else n_pass++;
            n_checks++;
            @(posedge clk); #1;
        end
        #3;
        if ({flags_q, illegal} !== 4'b1010)
            $display("FAIL branch_end: got %b want 1010", {flags_q, illegal});
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_lw_wait();
        logic [31:0] ins [9];
        logic [8:0]  mr;
        logic [2:0]  fl [9];
        logic [15:0] ex [9];
        ins = '{I_LW, I_JUNK, I_JUNK, I_JUNK, I_JUNK, I_JUNK, I_JUNK, I_JUNK, I_JUNK};
        mr  = 9'b111000110;
        fl  = '{3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        ex  = '{E_FETCH, 16'h0000, E_IMM, E_REQ, E_REQ, E_REQ, E_REQ, E_RWE | E_WBM, E_REQ};
        do_reset();
        for (int c = 0; c < 9; c++) begin
            instr = ins[c]; mem_ready = mr[8-c]; {carry, zero, sign} = fl[c];
            #3;
            if (obs !== ex[c]) $display("FAIL lw cyc%0d: got %h want %h", c + 1, obs, ex[c]);
            else n_pass++;
            n_checks++;
            @(posedge clk); #1;
        end
        #3;
        if (flags_q !== 3'b000) $display("FAIL lw_flags: got %b want 000", flags_q);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_sw();
        logic [31:0] ins [7];
        logic [6:0]  mr;
        logic [2:0]  fl [7];
        logic [15:0] ex [7];
        ins = '{I_JUNK, I_JUNK, I_SW, I_JUNK, I_JUNK, I_JUNK, I_JUNK};
        mr  = 7'b0011110;
        fl  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000};
        ex  = '{E_REQ, E_REQ, E_FETCH, 16'h0000, E_IMM, E_REQ | E_WE, E_REQ};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            instr = ins[c]; mem_ready = mr[6-c]; {carry, zero, sign} = fl[c];
            #3;
            if (obs !== ex[c]) $display("FAIL sw cyc%0d: got %h want %h", c + 1, obs, ex[c]);
            else n_pass++;
            n_checks++;
            @(posedge clk); #1;
        end
        #3;
        if (flags_q !== 3'b000) $display("FAIL sw_flags: got %b want 000", flags_q);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_halt();
        logic [31:0] ins [6];
        logic [5:0]  mr;
        logic [15:0] ex [6];
        ins = '{I_HALT, I_JUNK, I_RALU5, I_LW, I_B, I_SW};
        mr  = 6'b111101;
        ex  = '{E_FETCH, 16'h0000, E_HLT, E_HLT, E_HLT, E_HLT};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            instr = ins[c]; mem_ready = mr[5-c]; {carry, zero, sign} = 3'b111;
            #3;
            if (obs !== ex[c]) $display("FAIL halt cyc%0d: got %h want %h", c + 1, obs, ex[c]);
            else n_pass++;
            n_checks++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        if (obs !== 16'h0000) $display("FAIL halt_rst: got %h want 0000", obs);
        else n_pass++;
        n_checks++;
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
        #3;
        if (obs !== E_REQ) $display("FAIL halt_exit: got %h want %h", obs, E_REQ);
        else n_pass++;
        n_checks++;
        if (illegal !== 1'b0) $display("FAIL halt_ill: got %b want 0", illegal);
        else n_pass++;
        n_checks++;
    endtask

    initial begin
        rst = 1'b1;
        instr = I_JUNK;
        mem_ready = 1'b0;
        {carry, zero, sign} = 3'b000;
        test_ralu();
        test_reset();
        test_neg_illegal();
        test_branch();
        test_lw_wait();
        test_sw();
        test_halt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
